// File: rtl/puf_key_sequencer_pkg.sv
// Shared definitions for the PUF key sequencer.
//   - Default sizing constants for the RO-pair array, counter width,
//     number of vote rounds and the result timeout.
//   - Sequencer FSM state encoding.
//   - Helper returning the width needed to count 0..n inclusive.
package puf_key_sequencer_pkg;

    localparam int unsigned NROP_DEF  = 256;
    localparam int unsigned ACC_DEF   = 7;
    localparam int unsigned NVOTE_DEF = 5;
    localparam int unsigned TMO_DEF   = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_vote_cell.sv
// Majority-vote cell for one RO pair.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : clear the vote counter (start of a new key run)
//   inc_en    : sample strobe; counter increments if the pair sign bit is set
//   pair      : ACC-bit signed difference for this pair (MSB = sign)
//   key_bit   : 1 when more than half of the rounds saw a set sign bit
//   mask_bit  : 1 when the rounds disagreed (neither all-0 nor all-1)
module puf_vote_cell
    import puf_key_sequencer_pkg::*;
#(
    parameter int unsigned ACC   = ACC_DEF,
    parameter int unsigned NVOTE = NVOTE_DEF
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    input  logic           inc_en,
    input  logic [ACC-1:0] pair,
    output logic           key_bit,
    output logic           mask_bit
);

    localparam int unsigned CW = cnt_width(NVOTE);

    logic [CW-1:0] cnt;

    // Only NVOTE samples are taken per run, so the counter never wraps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc_en && pair[ACC-1]) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        key_bit  = (cnt > CW'(NVOTE / 2));
        mask_bit = (cnt != '0) && (cnt != CW'(NVOTE));
    end

    // Magnitude bits carry no information for the vote.
    generate
        if (ACC > 1) begin : g_mag
            logic unused_mag;
            assign unused_mag = ^pair[ACC-2:0];
        end
    endgenerate

endmodule

// File: rtl/puf_key_sequencer.sv
// PUF key sequencer: runs NVOTE measurement rounds against a ring-oscillator
// PUF, majority-votes the sign of each pair difference into a key bit and
// flags pairs that disagreed across rounds in a mask.
//   clk, rstn            : clock, asynchronous active-low reset
//   start                : one-cycle request to generate a key (IDLE only)
//   busy                 : high whenever the sequencer is not idle
//   req_valid/req_ready  : measurement request handshake to the PUF
//   res_valid/res_ready  : result handshake from the PUF; co_v sampled
//                          in the cycle res_valid is seen while waiting
//   co_v                 : NROP packed ACC-bit signed pair differences
//   key, mask, err       : voted key, instability mask, timeout flag
//   key_valid/key_ready  : result handshake to the consumer
module puf_key_sequencer
    import puf_key_sequencer_pkg::*;
#(
    parameter int unsigned NROP  = NROP_DEF,
    parameter int unsigned ACC   = ACC_DEF,
    parameter int unsigned NVOTE = NVOTE_DEF,
    parameter int unsigned TMO   = TMO_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                busy,
    output logic                req_valid,
    input  logic                req_ready,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [ACC*NROP-1:0] co_v,
    output logic [NROP-1:0]     key,
    output logic [NROP-1:0]     mask,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                err
);

    localparam int unsigned RW = cnt_width(NVOTE);
    localparam int unsigned TW = cnt_width(TMO);

    seq_state_t state_q, state_d;

    logic [RW-1:0]   round_q;
    logic [TW-1:0]   tmo_q;
    logic [NROP-1:0] key_w;
    logic [NROP-1:0] mask_w;

    logic run_clr;
    logic sample;
    logic tmo_clr;
    logic tmo_inc;
    logic round_inc;
    logic done_ok;
    logic done_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        key_valid = 1'b0;
        run_clr   = 1'b0;
        sample    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        round_inc = 1'b0;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    run_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    tmo_clr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    sample  = 1'b1;
                    state_d = ST_CAPT;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    done_err = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_CAPT: begin
                res_ready = 1'b1;
                if (round_q == RW'(NVOTE - 1)) begin
                    done_ok = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    round_inc = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_DONE: begin
                key_valid = 1'b1;
                if (key_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            round_q <= '0;
        end else if (run_clr) begin
            round_q <= '0;
        end else if (round_inc) begin
            round_q <= round_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else if (run_clr || tmo_clr) begin
            tmo_q <= '0;
        end else if (tmo_inc) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Result registers are loaded on the transition into DONE, so they stay
    // frozen through the consumer handshake and after it until the next start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key  <= '0;
            mask <= '0;
            err  <= 1'b0;
        end else if (run_clr) begin
            key  <= '0;
            mask <= '0;
            err  <= 1'b0;
        end else if (done_err) begin
            key  <= '0;
            mask <= '1;
            err  <= 1'b1;
        end else if (done_ok) begin
            key  <= key_w;
            mask <= mask_w;
        end
    end

    generate
        for (genvar i = 0; i < NROP; i++) begin : g_cell
            puf_vote_cell #(
                .ACC   (ACC),
                .NVOTE (NVOTE)
            ) u_cell (
                .clk      (clk),
                .rstn     (rstn),
                .clr      (run_clr),
                .inc_en   (sample),
                .pair     (co_v[i*ACC +: ACC]),
                .key_bit  (key_w[i]),
                .mask_bit (mask_w[i])
            );
        end
    endgenerate

endmodule

// File: doc/puf_key_sequencer.md
PUF_KEY_SEQUENCER -- requirements
Module: puf_key_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NROP, 256, RO pairs in the PUF; ACC, 7, counter width per pair; NVOTE, 5, measurement rounds (odd, 1..15); TMO, 4096, max cycles waiting for res_valid.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock.
REQ-003 rstn, in, 1, reset, asynchronous, active-low.
REQ-004 start, in, 1, one-cycle request to generate a key.
REQ-005 busy, out, 1, high whenever state is not IDLE.
REQ-006 req_valid, out, 1, measurement request to PUF.
REQ-007 req_ready, in, 1, PUF accepts request.
REQ-008 res_valid, in, 1, PUF result available.
REQ-009 res_ready, out, 1, result consumed.
REQ-010 co_v, in, ACC*NROP, per-pair signed differences; pair i occupies bits [i*ACC+ACC-1 : i*ACC].
REQ-011 key, out, NROP, voted key bits.
REQ-012 mask, out, NROP, 1 = bit unstable across rounds.
REQ-013 key_valid, out, 1, key/mask/err valid.
REQ-014 key_ready, in, 1, consumer accepts key.
REQ-015 err, out, 1, timeout occurred in this run.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, CAPT, DONE.
REQ-017 IDLE: start=1 -> clear vote counters, round=0, err=0, go REQ; start outside IDLE SHALL be ignored.
REQ-018 REQ: req_valid=1; on the cycle req_valid&&req_ready -> req_valid=0 next cycle, timeout counter=0, go WAIT.
REQ-019 WAIT: res_ready=0; on res_valid=1, sample co_v that cycle and go CAPT; otherwise increment the timeout counter; on reaching TMO-1 -> err=1, go DONE.
REQ-020 CAPT: res_ready=1 for exactly one cycle; round == NVOTE-1 -> DONE, else round+1 -> REQ.
REQ-021 Vote: per pair a counter of width clog2(NVOTE+1), incremented when sign bit co_v[i*ACC+ACC-1] is 1 at the sampled edge; no saturation (cannot exceed NVOTE).
REQ-022 On entry to DONE: key[i] = (cnt[i] > NVOTE/2); mask[i] = (cnt[i] != 0 && cnt[i] != NVOTE); on err, key=0 and mask=all ones.
REQ-023 DONE: key_valid=1 and key/mask/err held stable until key_valid&&key_ready; then key_valid=0, go IDLE. key/mask/err retain their values until the next start.
REQ-024 Latency SHALL be minimal: at most one idle cycle between CAPT and the next req_valid; key_valid rises the cycle after the final CAPT.
REQ-025 res_valid outside WAIT and req_ready outside REQ SHALL be ignored.
REQ-026 key_ready in the same cycle key_valid first rises SHALL complete the handshake.

Reset
REQ-027 rstn=0 SHALL asynchronously force IDLE and clear all outputs, vote counters, round, and timeout counter to 0, including mid-measurement; the PUF's own reset is outside this block.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the default NROP/ACC/NVOTE/TMO constants.
REQ-029 One sub-module puf_vote_cell (one pair: counter, key bit, mask bit) SHALL be instantiated NROP times by generate.

Verification (NROP=4, ACC=7, NVOTE=3, TMO=16)
REQ-030 Sign bits identical all rounds (pair0..3 = 1,0,1,0), with req_ready and res_valid responsive -> key=4'b0101, mask=0, err=0, exactly 3 req transfers and 3 res_ready pulses.
REQ-031 Pair1 sign 1,0,1 across rounds, others constant -> key[1]=1, mask=4'b0010.
REQ-032 res_valid never asserted -> err=1 after 16 WAIT cycles, key=0, mask=4'hF, key_valid=1.
REQ-033 key_ready held low for 10 cycles -> key_valid, key, mask stable for all 10; start pulses during that time ignored.
REQ-034 rstn low during the second WAIT -> all outputs 0 immediately; a fresh start yields a correct 3-round result.
REQ-035 req_ready delayed 5 cycles, res_valid pulsed in the same cycle the FSM enters WAIT -> result captured, no extra or missing round.
